spi_slave: RTL

- SPI target (responder), mode 0 (CPOL=0, CPHA=0), MSB first. It is the far end of the SPI master pins brought out on the board top level: spi_clk, spi_mosi, spi_cs driven in, spi_miso driven out.
- Oversamples the asynchronous SPI pins in the system clock domain.
- Exposes received bytes and accepts transmit bytes via valid/ready-style handshakes to a picoRV32 port or to test logic.
- Requires f(clk) >= 4 x f(spi_clk).

---
 rtl/spi_slave.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   SPI target, mode 0 (CPOL=0, CPHA=0), MSB first. The SPI pins are treated
//   as asynchronous and oversampled in the clk domain, so f(clk) must be at
//   least 4x f(spi_clk). Received words and words to transmit are exchanged
//   with the local side through valid/ready-style handshakes.
//
// Optional build macro: SPI_SLAVE_OVERRUN_EN
//   Adds sticky rx_overrun / tx_underrun flags, a status_clr input that clears
//   them, and an rx_ack input that acknowledges a received word.
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   reset        in   synchronous, active-high reset
//   spi_clk      in   SPI serial clock (asynchronous)
//   spi_mosi     in   master-out data (asynchronous)
//   spi_cs       in   chip select, active low (asynchronous)
//   spi_miso     out  slave-out data
//   spi_miso_oe  out  MISO output enable, high while selected
//   tx_data      in   next word to transmit
//   tx_valid     in   tx_data is valid
//   tx_ready     out  transmit holding register empty
//   rx_data      out  last complete received word
//   rx_valid     out  one-cycle strobe, rx_data updated
//   busy         out  frame in progress
//   status_clr   in   (macro) clear both sticky flags
//   rx_ack       in   (macro) local side has consumed rx_data
//   rx_overrun   out  (macro) word received before the previous one was acked
//   tx_underrun  out  (macro) DEFAULT_TX sent mid-frame for lack of a word
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = 8'hFF,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_cs,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic                  status_clr,
  input  logic                  rx_ack,
  output logic                  rx_overrun,
  output logic                  tx_underrun
`endif
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_mosi_sync, r_cs_sync;
  logic                   r_sck_d, r_cs_d;
  logic                   w_sck, w_mosi, w_cs;
  logic                   w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;

  state_t                 r_state, w_state_nx;
  logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nx;
  logic [DATA_WIDTH-1:0]  r_rx_shift, w_rx_shift_nx;
  logic [DATA_WIDTH-1:0]  r_tx_shift, w_tx_shift_nx;
  logic [DATA_WIDTH-1:0]  r_hold, w_tx_word;
  logic                   r_hold_full;
  logic                   r_miso, w_miso_nx;
  logic                   r_word_done, w_word_done_nx;
  logic [DATA_WIDTH-1:0]  r_rx_data;
  logic                   r_rx_valid;
  logic                   w_rx_done, w_word_start, w_tx_accept;

  // Stage: pin synchronizers. Deliberately not reset: they keep tracking the
  // pins through reset, so a CS that is still low afterwards shows no falling
  // edge and the interrupted frame is ignored until CS is released.
  always_ff @(posedge clk) begin
    r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_clk};
    r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
    r_sck_d     <= w_sck;
    r_cs_d      <= w_cs;
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_rise =  w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck &  r_sck_d;
  assign w_cs_fall  = ~w_cs  &  r_cs_d;
  assign w_cs_rise  =  w_cs  & ~r_cs_d;

  // Stage: frame control, next-state logic
  always_comb begin
    w_state_nx     = r_state;
    w_bit_cnt_nx   = r_bit_cnt;
    w_rx_shift_nx  = r_rx_shift;
    w_tx_shift_nx  = r_tx_shift;
    w_miso_nx      = r_miso;
    w_word_done_nx = r_word_done;
    w_rx_done      = 1'b0;
    w_word_start   = 1'b0;
    w_tx_word      = r_hold_full ? r_hold : DEFAULT_TX;

    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nx     = ST_ACTIVE;
          w_bit_cnt_nx   = '0;
          w_word_done_nx = 1'b0;
          w_word_start   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // CS release has priority over any SCK edge seen in the same cycle.
        if (w_cs_rise) begin
          w_state_nx     = ST_IDLE;
          w_bit_cnt_nx   = '0;
          w_word_done_nx = 1'b0;
          w_miso_nx      = 1'b0;
        end else if (w_sck_rise) begin
          w_rx_shift_nx = {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_cnt_nx   = '0;
            w_rx_done      = 1'b1;
            w_word_done_nx = 1'b1;
          end else begin
            w_bit_cnt_nx = r_bit_cnt + 1'b1;
          end
        end else if (w_sck_fall) begin
          if (r_bit_cnt != '0) begin
            w_tx_shift_nx = {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            w_miso_nx     = r_tx_shift[DATA_WIDTH-2];
          end else if (r_word_done) begin
            // Falling edge after the last bit of a word opens the next word.
            w_word_start   = 1'b1;
            w_word_done_nx = 1'b0;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase

    if (w_word_start) begin
      w_tx_shift_nx = w_tx_word;
      w_miso_nx     = w_tx_word[DATA_WIDTH-1];
    end
  end

  // Loading and consuming the holding register are mutually exclusive: a word
  // start only consumes when full, a handshake only loads when empty.
  assign w_tx_accept = tx_valid && !r_hold_full;

  // Stage: registered frame state and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b0;
      r_word_done <= 1'b0;
      r_hold_full <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_bit_cnt   <= w_bit_cnt_nx;
      r_miso      <= w_miso_nx;
      r_word_done <= w_word_done_nx;
      r_rx_valid  <= w_rx_done;
      if (w_rx_done) begin
        r_rx_data <= w_rx_shift_nx;
      end
      if (w_word_start && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (w_tx_accept) begin
        r_hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_rx_shift <= w_rx_shift_nx;
    r_tx_shift <= w_tx_shift_nx;
    if (w_tx_accept) begin
      r_hold <= tx_data;
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = (r_state == ST_ACTIVE);
  assign busy        = (r_state == ST_ACTIVE);
  assign tx_ready    = ~r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic r_rx_unacked, r_rx_overrun, r_tx_underrun;
  logic w_overrun_set, w_underrun_set;

  // Only word starts inside a frame count as underrun; the frame-opening word
  // start happens on the way out of IDLE.
  assign w_overrun_set  = w_rx_done && r_rx_unacked && !rx_ack;
  assign w_underrun_set = w_word_start && (r_state == ST_ACTIVE) && !r_hold_full;

  // Stage: sticky status flags, set wins over clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_unacked  <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_rx_unacked  <= w_rx_done | (r_rx_unacked & ~rx_ack);
      r_rx_overrun  <= w_overrun_set  | (r_rx_overrun  & ~status_clr);
      r_tx_underrun <= w_underrun_set | (r_tx_underrun & ~status_clr);
    end
  end

  assign rx_overrun  = r_rx_overrun;
  assign tx_underrun = r_tx_underrun;
`endif

endmodule
